turn_ctl: RTL and testbench
===========================

Name: turn_ctl

Overview:
- Game-level scheduler for the two projectile datapaths: the cat throw controller and the dog throw controller.
- Alternates turns and accumulates the thrower's force while the fire button is held.
- Draws a fresh wind value per turn, drives the active controller's enable, and books hits into hit-point counters.
- Declares the winner. Sits between the debounced input/keyboard logic and the two throw controllers; outputs also feed the HUD draw blocks.

Parameters:
- HP_INIT, 100, starting hit points per player (7-bit range).
- DAMAGE, 20, HP removed per registered hit.
- CHARGE_DIV, 130000, clk cycles per +1 force step while charging (100 µs at 1.3 GHz-equivalent tick; counter width 18 bits).
- FORCE_MAX, 1023, saturation value of throw_force.
- LFSR_SEED, 7'h5A, nonzero wind LFSR reset seed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_fire  in  1  synchronous, debounced fire button; high = charging
- throw_done_cat  in  1  cat controller finished (level, held until its enable drops)
- throw_done_dog  in  1  dog controller finished
- hit_by_cat  in  1  one-cycle pulse: cat projectile entered dog box
- hit_by_dog  in  1  one-cycle pulse: dog projectile entered cat box
- enable_cat  out  1  enable to cat throw controller
- enable_dog  out  1  enable to dog throw controller
- throw_force  out  10  force for the active thrower, unsigned
- wind_force  out  7  wind 0..100, 50 = calm
- hp_cat  out  7  cat hit points
- hp_dog  out  7  dog hit points
- turn_dog  out  1  0 = cat's turn, 1 = dog's turn
- game_over  out  1  high in ST_OVER
- winner_dog  out  1  valid when game_over; 1 = dog won

Behaviour:
- Reset (async, rst_n low):
  - State goes to ST_AIM; turn_dog=0.
  - enable_cat=0, enable_dog=0, throw_force=0.
  - LFSR=LFSR_SEED; wind_force = mapped seed value (90).
  - hp_cat=hp_dog=HP_INIT; game_over=0, winner_dog=0.
  - The charge divider clears.
- Outputs: all are registered; no combinational path from inputs.
- Wind generation:
  - 7-bit Fibonacci LFSR, taps x^7+x^6+1. It steps every clk and never reaches 0.
  - On entry to ST_AIM, wind_force is loaded from the LFSR: value v if v ≤ 100, else v−27. The result is always 0..100.
  - wind_force is held constant for the rest of the turn.
- ST_AIM:
  - Both enables are 0.
  - While btn_fire=1, the divider counts. On reaching CHARGE_DIV−1, the divider wraps to 0 and throw_force increments, saturating at FORCE_MAX.
  - On btn_fire falling (registered previous sample = 1, current = 0), go to ST_THROW.
  - A press shorter than one step leaves force 0. This is legal; the throw still fires.
- ST_THROW:
  - enable_cat = ~turn_dog and enable_dog = turn_dog, asserted from the first cycle in the state.
  - throw_force is frozen; btn_fire is ignored.
  - When the active throw_done_* is 1, deassert both enables and go to ST_RELEASE.
- ST_RELEASE:
  - Both enables are 0. Wait until the active throw_done_* reads 0.
  - Then, if either HP is 0, go to ST_OVER.
  - Otherwise toggle turn_dog, clear throw_force and the divider, reload wind_force, and go to ST_AIM.
- Hit booking:
  - hit_by_cat is counted only when state=ST_THROW and turn_dog=0; hit_by_dog only when state=ST_THROW and turn_dog=1.
  - At most one hit is counted per throw, tracked by a per-throw flag that clears on ST_THROW entry.
  - A counted hit subtracts DAMAGE from the victim's HP, saturating at 0 (if hp<DAMAGE, hp becomes 0).
  - A hit pulse and throw_done in the same cycle: the hit is still booked.
  - Off-turn or out-of-state pulses are ignored.
- ST_OVER:
  - Enables are 0; game_over=1.
  - winner_dog = (hp_cat==0). Both HP cannot reach 0 in one throw.
  - A rising edge of btn_fire restarts the game: HP reloads, turn_dog=0, game_over=0, and the state goes to ST_AIM with a new wind value.
- Unused state encoding: next cycle goes to ST_AIM with both enables 0.
- Reset mid-throw: enables drop asynchronously at once. The throw controllers return to idle on the enable drop.

Test Plan:
- Reset: release rst_n → hp_cat=hp_dog=100, wind_force=90, turn_dog=0, both enables 0, throw_force=0.
- Charge: set CHARGE_DIV=4 in the bench and hold btn_fire 40 cycles → throw_force=10. Then release → enable_cat=1 on the next cycle, with throw_force still 10.
- Saturation: with CHARGE_DIV=1, hold btn_fire 1100 cycles → throw_force stops at 1023.
- Turn swap: in the cat turn, pulse throw_done_cat high for 5 cycles then low → enable_cat=0 the cycle after done. Then turn_dog=1, throw_force=0, and wind_force is a new value in the range 0..100.
- Hit booking:
  - Two hit_by_cat pulses within one cat throw → hp_dog=80, not 60.
  - hit_by_dog during the cat turn → hp_cat unchanged at 100.
- Game over: book 5 cat hits across 5 cat turns → hp_dog=0, game_over=1, winner_dog=0, both enables 0. A btn_fire rising edge then → HP back to 100 and game_over=0.

Source files
------------

// File: rtl/turn_ctl.sv
// Turn scheduler for the cat/dog artillery game: alternates turns, charges throw force,
// draws wind per turn, books hits into HP counters and declares the winner.
module turn_ctl #(
    parameter int unsigned HP_INIT    = 100,
    parameter int unsigned DAMAGE     = 20,
    parameter int unsigned CHARGE_DIV = 130000,
    parameter int unsigned FORCE_MAX  = 1023,
    parameter logic [6:0]  LFSR_SEED  = 7'h5A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_fire,
    input  logic       throw_done_cat,
    input  logic       throw_done_dog,
    input  logic       hit_by_cat,
    input  logic       hit_by_dog,
    output logic       enable_cat,
    output logic       enable_dog,
    output logic [9:0] throw_force,
    output logic [6:0] wind_force,
    output logic [6:0] hp_cat,
    output logic [6:0] hp_dog,
    output logic       turn_dog,
    output logic       game_over,
    output logic       winner_dog
);

    localparam logic [17:0] DivLast  = 18'(CHARGE_DIV - 1);
    localparam logic [9:0]  ForceTop = 10'(FORCE_MAX);
    localparam logic [6:0]  HpFull   = 7'(HP_INIT);
    localparam logic [6:0]  Dmg      = 7'(DAMAGE);

    typedef enum logic [1:0] {StAim, StThrow, StRelease, StOver} state_e;

    // Folds LFSR range 1..127 onto 0..100.
    function automatic logic [6:0] map_wind(input logic [6:0] v);
        return (v > 7'd100) ? v - 7'd27 : v;
    endfunction

    function automatic logic [6:0] take_hit(input logic [6:0] hp);
        return (hp < Dmg) ? 7'd0 : hp - Dmg;
    endfunction

    state_e      state_q, state_d;
    logic        turn_q, turn_d;
    logic [9:0]  force_q, force_d;
    logic [17:0] div_q, div_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic [6:0]  wind_q, wind_d;
    logic [6:0]  hp_cat_q, hp_cat_d;
    logic [6:0]  hp_dog_q, hp_dog_d;
    logic        en_cat_q, en_cat_d;
    logic        en_dog_q, en_dog_d;
    logic        over_q, over_d;
    logic        winner_q, winner_d;
    logic        btn_prev_q;
    logic        hit_q, hit_d;
    logic        active_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StAim;
            turn_q     <= 1'b0;
            force_q    <= '0;
            div_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            wind_q     <= map_wind(LFSR_SEED);
            hp_cat_q   <= HpFull;
            hp_dog_q   <= HpFull;
            en_cat_q   <= 1'b0;
            en_dog_q   <= 1'b0;
            over_q     <= 1'b0;
            winner_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            turn_q     <= turn_d;
            force_q    <= force_d;
            div_q      <= div_d;
            lfsr_q     <= lfsr_d;
            wind_q     <= wind_d;
            hp_cat_q   <= hp_cat_d;
            hp_dog_q   <= hp_dog_d;
            en_cat_q   <= en_cat_d;
            en_dog_q   <= en_dog_d;
            over_q     <= over_d;
            winner_q   <= winner_d;
            btn_prev_q <= btn_fire;
            hit_q      <= hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        turn_d      = turn_q;
        force_d     = force_q;
        div_d       = div_q;
        lfsr_d      = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        wind_d      = wind_q;
        hp_cat_d    = hp_cat_q;
        hp_dog_d    = hp_dog_q;
        en_cat_d    = 1'b0;
        en_dog_d    = 1'b0;
        over_d      = over_q;
        winner_d    = winner_q;
        hit_d       = hit_q;
        active_done = turn_q ? throw_done_dog : throw_done_cat;

        case (state_q)
            StAim: begin
                if (btn_fire) begin
                    if (div_q == DivLast) begin
                        div_d = '0;
                        if (force_q != ForceTop) force_d = force_q + 10'd1;
                    end else begin
                        div_d = div_q + 18'd1;
                    end
                end else if (btn_prev_q) begin
                    state_d  = StThrow;
                    en_cat_d = ~turn_q;
                    en_dog_d = turn_q;
                    hit_d    = 1'b0;
                end
            end
            StThrow: begin
                // A hit in the same cycle as throw_done is still booked.
                if (!hit_q) begin
                    if (!turn_q && hit_by_cat) begin
                        hp_dog_d = take_hit(hp_dog_q);
                        hit_d    = 1'b1;
                    end else if (turn_q && hit_by_dog) begin
                        hp_cat_d = take_hit(hp_cat_q);
                        hit_d    = 1'b1;
                    end
                end
                if (active_done) begin
                    state_d = StRelease;
                end else begin
                    en_cat_d = ~turn_q;
                    en_dog_d = turn_q;
                end
            end
            StRelease: begin
                if (!active_done) begin
                    if (hp_cat_q == 7'd0 || hp_dog_q == 7'd0) begin
                        state_d  = StOver;
                        over_d   = 1'b1;
                        winner_d = (hp_cat_q == 7'd0);
                    end else begin
                        state_d = StAim;
                        turn_d  = ~turn_q;
                        force_d = '0;
                        div_d   = '0;
                        wind_d  = map_wind(lfsr_q);
                    end
                end
            end
            StOver: begin
                if (btn_fire && !btn_prev_q) begin
                    state_d  = StAim;
                    hp_cat_d = HpFull;
                    hp_dog_d = HpFull;
                    turn_d   = 1'b0;
                    over_d   = 1'b0;
                    winner_d = 1'b0;
                    force_d  = '0;
                    div_d    = '0;
                    wind_d   = map_wind(lfsr_q);
                end
            end
            default: state_d = StAim;
        endcase
    end

    assign enable_cat  = en_cat_q;
    assign enable_dog  = en_dog_q;
    assign throw_force = force_q;
    assign wind_force  = wind_q;
    assign hp_cat      = hp_cat_q;
    assign hp_dog      = hp_dog_q;
    assign turn_dog    = turn_q;
    assign game_over   = over_q;
    assign winner_dog  = winner_q;

endmodule

// File: tb/tb_turn_ctl.sv
// Directed bench for turn_ctl: a fast-charge instance for game flow and a
// divide-by-one instance for force saturation.
module tb_turn_ctl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_fire = 1'b0;
    logic       btn_sat = 1'b0;
    logic       done_cat = 1'b0;
    logic       done_dog = 1'b0;
    logic       hit_cat = 1'b0;
    logic       hit_dog = 1'b0;

    logic       enable_cat, enable_dog, turn_dog, game_over, winner_dog;
    logic [9:0] throw_force;
    logic [6:0] wind_force, hp_cat, hp_dog;

    logic       s_en_cat, s_en_dog, s_turn, s_over, s_winner;
    logic [9:0] s_force;
    logic [6:0] s_wind, s_hp_cat, s_hp_dog;

    int errors = 0;
    int checks = 0;
    logic [6:0] wind_saved;

    always #5 clk = ~clk;

    turn_ctl #(.CHARGE_DIV(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_fire       (btn_fire),
        .throw_done_cat (done_cat),
        .throw_done_dog (done_dog),
        .hit_by_cat     (hit_cat),
        .hit_by_dog     (hit_dog),
        .enable_cat     (enable_cat),
        .enable_dog     (enable_dog),
        .throw_force    (throw_force),
        .wind_force     (wind_force),
        .hp_cat         (hp_cat),
        .hp_dog         (hp_dog),
        .turn_dog       (turn_dog),
        .game_over      (game_over),
        .winner_dog     (winner_dog)
    );

    turn_ctl #(.CHARGE_DIV(1)) dut_sat (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_fire       (btn_sat),
        .throw_done_cat (1'b0),
        .throw_done_dog (1'b0),
        .hit_by_cat     (1'b0),
        .hit_by_dog     (1'b0),
        .enable_cat     (s_en_cat),
        .enable_dog     (s_en_dog),
        .throw_force    (s_force),
        .wind_force     (s_wind),
        .hp_cat         (s_hp_cat),
        .hp_dog         (s_hp_dog),
        .turn_dog       (s_turn),
        .game_over      (s_over),
        .winner_dog     (s_winner)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cat turn that books exactly one hit, then a dog turn with no hit.
    task automatic cat_hit_then_dog_miss(input logic [6:0] hp_dog_exp, input bit do_dog);
        btn_fire = 1'b1; step(4);
        btn_fire = 1'b0; step(1);
        hit_cat  = 1'b1; step(1);
        hit_cat  = 1'b0;
        check("hp_dog_after_hit", 16'(hp_dog), 16'(hp_dog_exp));
        done_cat = 1'b1; step(1);
        done_cat = 1'b0; step(1);
        if (do_dog) begin
            btn_fire = 1'b1; step(4);
            btn_fire = 1'b0; step(1);
            done_dog = 1'b1; step(1);
            done_dog = 1'b0; step(1);
        end
    endtask

    initial begin
        step(3);
        rst_n = 1'b1;
        step(1);
        check("rst_hp_cat", 16'(hp_cat), 16'd100);
        check("rst_hp_dog", 16'(hp_dog), 16'd100);
        check("rst_wind", 16'(wind_force), 16'd90);
        check("rst_turn", 16'(turn_dog), 16'd0);
        check("rst_en_cat", 16'(enable_cat), 16'd0);
        check("rst_en_dog", 16'(enable_dog), 16'd0);
        check("rst_force", 16'(throw_force), 16'd0);
        check("rst_over", 16'(game_over), 16'd0);

        // Saturation on the divide-by-one instance.
        btn_sat = 1'b1; step(1022);
        check("sat_1022", 16'(s_force), 16'd1022);
        step(78);
        check("sat_1023", 16'(s_force), 16'd1023);
        btn_sat = 1'b0;
        check("wind_held_in_aim", 16'(wind_force), 16'd90);

        // Cat turn: charge 40 cycles at divide-by-4.
        btn_fire = 1'b1; step(40);
        check("charge_force", 16'(throw_force), 16'd10);
        check("charge_no_enable", 16'(enable_cat), 16'd0);
        btn_fire = 1'b0; step(1);
        check("throw_en_cat", 16'(enable_cat), 16'd1);
        check("throw_en_dog", 16'(enable_dog), 16'd0);
        check("throw_force_frozen", 16'(throw_force), 16'd10);

        // Two hits in one throw count once; off-turn hit ignored.
        hit_cat = 1'b1; step(1);
        hit_cat = 1'b0; step(1);
        hit_cat = 1'b1; step(1);
        hit_cat = 1'b0;
        check("one_hit_per_throw", 16'(hp_dog), 16'd80);
        hit_dog = 1'b1; step(1);
        hit_dog = 1'b0;
        check("offturn_hit", 16'(hp_cat), 16'd100);
        check("en_cat_still_on", 16'(enable_cat), 16'd1);

        // Turn swap.
        done_cat = 1'b1; step(1);
        check("en_cat_drop", 16'(enable_cat), 16'd0);
        step(4);
        check("hold_turn_in_release", 16'(turn_dog), 16'd0);
        done_cat = 1'b0; step(1);
        check("swap_turn", 16'(turn_dog), 16'd1);
        check("swap_force", 16'(throw_force), 16'd0);
        check("swap_wind_range", 16'(wind_force <= 7'd100), 16'd1);
        wind_saved = wind_force;

        // Dog turn: hit arrives in the same cycle as done.
        btn_fire = 1'b1; step(8);
        check("dog_force", 16'(throw_force), 16'd2);
        check("wind_stable", 16'(wind_force), 16'(wind_saved));
        btn_fire = 1'b0; step(1);
        check("dog_en_dog", 16'(enable_dog), 16'd1);
        check("dog_en_cat", 16'(enable_cat), 16'd0);
        hit_dog = 1'b1; done_dog = 1'b1; step(1);
        hit_dog = 1'b0;
        check("hit_with_done", 16'(hp_cat), 16'd80);
        check("dog_en_drop", 16'(enable_dog), 16'd0);
        done_dog = 1'b0; step(1);
        check("back_to_cat", 16'(turn_dog), 16'd0);

        // Four more cat hits finish the dog.
        cat_hit_then_dog_miss(7'd60, 1'b1);
        cat_hit_then_dog_miss(7'd40, 1'b1);
        cat_hit_then_dog_miss(7'd20, 1'b1);
        cat_hit_then_dog_miss(7'd0, 1'b0);
        check("over_flag", 16'(game_over), 16'd1);
        check("over_winner", 16'(winner_dog), 16'd0);
        check("over_en_cat", 16'(enable_cat), 16'd0);
        check("over_en_dog", 16'(enable_dog), 16'd0);
        check("over_hp_cat", 16'(hp_cat), 16'd80);
        step(3);
        check("over_sticky", 16'(game_over), 16'd1);

        // Restart on btn rising edge; the release then fires a zero-force throw.
        btn_fire = 1'b1; step(1);
        check("restart_over", 16'(game_over), 16'd0);
        check("restart_hp_cat", 16'(hp_cat), 16'd100);
        check("restart_hp_dog", 16'(hp_dog), 16'd100);
        check("restart_turn", 16'(turn_dog), 16'd0);
        check("restart_wind_range", 16'(wind_force <= 7'd100), 16'd1);
        btn_fire = 1'b0; step(1);
        check("short_press_fires", 16'(enable_cat), 16'd1);
        check("short_press_force", 16'(throw_force), 16'd0);

        // Asynchronous reset mid-throw drops the enable immediately.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_en", 16'(enable_cat), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
